// File: rtl/legv8_pkg.sv
// ----------------------------------------------------------------------------
// legv8_pkg
//   Shared LEGv8 datapath constants and types.
//   DATA_W   : architectural register / data port width
//   ADDR_W   : register index width
//   NUM_REGS : architectural register count (index NUM_REGS-1 is XZR)
//   XZR_IDX  : index of the hard-wired zero register
//   reg_idx_t, xword_t : index and data word types
// ----------------------------------------------------------------------------
package legv8_pkg;

   localparam int DATA_W   = 64;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 32;

   localparam logic [ADDR_W-1:0] XZR_IDX = 5'd31;

   typedef logic [ADDR_W-1:0] reg_idx_t;
   typedef logic [DATA_W-1:0] xword_t;

endpackage

// File: rtl/leg_register_file_read_port.sv
// ----------------------------------------------------------------------------
// regfile_read_port
//   One combinational read port of the LEGv8 register file: index decode,
//   XZR zeroing and, when REGFILE_BYPASS_EN is defined, write-through
//   forwarding of the in-flight write.
//   Ports:
//     idx_i      : register index to read
//     regs_i     : view of the physical storage X0..X30
//     byp_en_i   : a qualified write is in flight this cycle (never XZR,
//                  never during reset)
//     byp_idx_i  : index being written
//     byp_data_i : data being written
//     data_o     : read result
//   Build option: REGFILE_BYPASS_EN enables the forward mux; without it the
//   bypass inputs are unused and the stored value is returned.
// ----------------------------------------------------------------------------
module regfile_read_port
   import legv8_pkg::*;
(
   input  reg_idx_t idx_i,
   input  xword_t   regs_i [NUM_REGS-1],
   input  logic     byp_en_i,
   input  reg_idx_t byp_idx_i,
   input  xword_t   byp_data_i,
   output xword_t   data_o
);

`ifdef REGFILE_BYPASS_EN
   // byp_en_i already excludes XZR, so a match here can never be index 31.
   logic fwd_hit;
   assign fwd_hit = byp_en_i && (byp_idx_i == idx_i);

   always_comb begin
      data_o = '0;
      if (fwd_hit) begin
         data_o = byp_data_i;
      end else if (idx_i != XZR_IDX) begin
         data_o = regs_i[idx_i];
      end
   end
`else
   logic unused_byp;
   assign unused_byp = byp_en_i ^ (^byp_idx_i) ^ (^byp_data_i);

   always_comb begin
      data_o = '0;
      if (idx_i != XZR_IDX) begin
         data_o = regs_i[idx_i];
      end
   end
`endif

endmodule

// File: rtl/leg_register_file.sv
// ----------------------------------------------------------------------------
// leg_register_file
//   LEGv8 architectural register file: 32 x 64-bit, two asynchronous read
//   ports, one synchronous write port. X31 (XZR) has no storage, reads 0 and
//   silently drops writes.
//   Ports:
//     clk        : system clock, rising edge active
//     rst_n      : asynchronous active-low reset, clears X0..X30
//     read_reg1  : read port 1 index (Instruction[9:5])
//     read_reg2  : read port 2 index (Reg2Loc mux output)
//     write_reg  : write index (Instruction[4:0])
//     write_data : writeback value
//     reg_write  : write enable (RegWrite)
//     read_data1 : contents of read_reg1
//     read_data2 : contents of read_reg2
//   Build option: define REGFILE_BYPASS_EN for write-through forwarding on
//   both read ports (pipelined build); leave undefined for the single-cycle
//   build, where a new value becomes visible only after the write edge.
// ----------------------------------------------------------------------------
module leg_register_file
   import legv8_pkg::*;
(
   input  logic     clk,
   input  logic     rst_n,
   input  reg_idx_t read_reg1,
   input  reg_idx_t read_reg2,
   input  reg_idx_t write_reg,
   input  xword_t   write_data,
   input  logic     reg_write,
   output xword_t   read_data1,
   output xword_t   read_data2
);

   // Physical storage for X0..X30 only.
   xword_t regs_q [NUM_REGS-1];
   xword_t regs_d [NUM_REGS-1];

   // A write that will actually change state; also the forwarding qualifier,
   // so reset and XZR writes are never forwarded.
   logic wr_en;
   assign wr_en = rst_n && reg_write && (write_reg != XZR_IDX);

   always_comb begin
      regs_d = regs_q;
      if (wr_en) begin
         regs_d[write_reg] = write_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS - 1; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // An unknown write index with the enable high would corrupt an unknown
   // register; flag it loudly in simulation.
   always_ff @(posedge clk) begin
      if (rst_n && reg_write) begin
         assert (!$isunknown(write_reg))
            else $error("leg_register_file: unknown write_reg with reg_write=1");
      end
   end

   regfile_read_port u_rp1 (
      .idx_i      (read_reg1),
      .regs_i     (regs_q),
      .byp_en_i   (wr_en),
      .byp_idx_i  (write_reg),
      .byp_data_i (write_data),
      .data_o     (read_data1)
   );

   regfile_read_port u_rp2 (
      .idx_i      (read_reg2),
      .regs_i     (regs_q),
      .byp_en_i   (wr_en),
      .byp_idx_i  (write_reg),
      .byp_data_i (write_data),
      .data_o     (read_data2)
   );

endmodule

// File: tb/tb_leg_register_file.sv
module tb_leg_register_file;
   import legv8_pkg::*;

   logic     clk;
   logic     rst_n;
   reg_idx_t read_reg1;
   reg_idx_t read_reg2;
   reg_idx_t write_reg;
   xword_t   write_data;
   logic     reg_write;
   xword_t   read_data1;
   xword_t   read_data2;

   int checks = 0;
   int errors = 0;

   leg_register_file dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .read_reg1  (read_reg1),
      .read_reg2  (read_reg2),
      .write_reg  (write_reg),
      .write_data (write_data),
      .reg_write  (reg_write),
      .read_data1 (read_data1),
      .read_data2 (read_data2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input xword_t obs, input xword_t exp);
      checks++;
      assert (obs === exp)
         else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
         end
   endtask

   // One write through the normal port, enable dropped just after the edge.
   task automatic wr(input reg_idx_t idx, input xword_t data);
      @(negedge clk);
      reg_write  = 1'b1;
      write_reg  = idx;
      write_data = data;
      @(posedge clk);
      #1;
      reg_write  = 1'b0;
   endtask

   xword_t same_cycle_exp;

   initial begin
      rst_n      = 1'b0;
      read_reg1  = '0;
      read_reg2  = '0;
      write_reg  = '0;
      write_data = '0;
      reg_write  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset state
      read_reg1 = 5'd0; read_reg2 = 5'd30; #1;
      chk("rst_x0", read_data1, 64'd0);
      chk("rst_x30", read_data2, 64'd0);

      // 1. Asynchronous reset mid-cycle clears a preloaded register
      wr(5'd5, 64'hDEAD);
      read_reg1 = 5'd5; #1;
      chk("preload_x5", read_data1, 64'hDEAD);
      @(negedge clk); #2;
      rst_n = 1'b0; #1;
      chk("async_rst_x5", read_data1, 64'd0);
      @(negedge clk);
      rst_n = 1'b1; #1;
      chk("post_rst_x5", read_data1, 64'd0);

      // 2. Basic write then read on both ports
      wr(5'd9, 64'h0000_0000_1234_5678);
      read_reg1 = 5'd9; read_reg2 = 5'd9; #1;
      chk("wr_x9_p2", read_data2, 64'h0000_0000_1234_5678);
      chk("wr_x9_p1", read_data1, 64'h0000_0000_1234_5678);

      // Boundary registers X0 and X30, independent ports
      wr(5'd0, 64'h0123_4567_89AB_CDEF);
      wr(5'd30, 64'hA5A5_5A5A_0F0F_F0F0);
      read_reg1 = 5'd0; read_reg2 = 5'd30; #1;
      chk("wr_x0", read_data1, 64'h0123_4567_89AB_CDEF);
      chk("wr_x30", read_data2, 64'hA5A5_5A5A_0F0F_F0F0);

      // 3. Writes to XZR are dropped and XZR always reads zero
      @(negedge clk);
      reg_write  = 1'b1;
      write_reg  = 5'd31;
      write_data = 64'hFFFF_FFFF_FFFF_FFFF;
      read_reg1  = 5'd31;
      read_reg2  = 5'd31;
      #1;
      chk("xzr_pre_p1", read_data1, 64'd0);
      chk("xzr_pre_p2", read_data2, 64'd0);
      @(posedge clk); #1;
      reg_write = 1'b0;
      chk("xzr_post_p1", read_data1, 64'd0);
      chk("xzr_post_p2", read_data2, 64'd0);
      read_reg1 = 5'd30; #1;
      chk("xzr_x30_intact", read_data1, 64'hA5A5_5A5A_0F0F_F0F0);

      // 4. Enable gating: reg_write=0 leaves state alone over 3 edges
      wr(5'd3, 64'd7);
      @(negedge clk);
      reg_write  = 1'b0;
      write_reg  = 5'd3;
      write_data = 64'd99;
      repeat (3) @(posedge clk);
      #1;
      read_reg1 = 5'd3; #1;
      chk("gate_x3", read_data1, 64'd7);

      // 5. Same-cycle read/write of one register
      wr(5'd4, 64'd1);
`ifdef REGFILE_BYPASS_EN
      same_cycle_exp = 64'd2;
`else
      same_cycle_exp = 64'd1;
`endif
      @(negedge clk);
      reg_write  = 1'b1;
      write_reg  = 5'd4;
      write_data = 64'd2;
      read_reg2  = 5'd4;
      read_reg1  = 5'd9;
      #1;
      chk("rw_same_pre", read_data2, same_cycle_exp);
      chk("rw_other_port", read_data1, 64'h0000_0000_1234_5678);
      @(posedge clk); #1;
      reg_write = 1'b0;
      chk("rw_same_post", read_data2, 64'd2);

      // 6. Writes during reset are discarded and never forwarded
      @(negedge clk);
      rst_n      = 1'b0;
      reg_write  = 1'b1;
      write_reg  = 5'd6;
      write_data = 64'd5;
      read_reg1  = 5'd6;
      #1;
      chk("rst_wr_during", read_data1, 64'd0);
      @(posedge clk);
      @(negedge clk);
      reg_write = 1'b0;
      rst_n     = 1'b1;
      #1;
      chk("rst_wr_x6", read_data1, 64'd0);
      read_reg2 = 5'd4; #1;
      chk("rst_wr_x4_cleared", read_data2, 64'd0);

      // First edge after release accepts a write
      wr(5'd6, 64'h55);
      chk("post_rel_wr_x6", read_data1, 64'h55);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
